// File: rtl/fetch_pkg.sv
// Shared widths, reset address and the buffered fetch-entry layout for the fetch front end.
package fetch_pkg;

    localparam int                        DEFAULT_ADDR_W   = 16;
    localparam int                        DEFAULT_INSTR_W  = 16;
    localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0]  pc;
        logic [DEFAULT_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries; the head is presented directly from storage
// and forced to zero while the buffer is empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic             head_valid,
    output logic [CNT_W-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    assign occupancy  = count;
    assign head       = head_valid ? mem[rd_ptr] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // When full, a push is only legal together with a pop (the write lands in the slot being freed).
    no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
        !(push && (count == CNT_W'(DEPTH)) && !do_pop));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch requester: owns the PC, issues reads under a credit rule, tracks in-flight
// reads through a latency pipeline and buffers returned instructions for decode.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = DEFAULT_ADDR_W,
    parameter int                INSTR_W    = DEFAULT_INSTR_W,
    parameter int                IM_LATENCY = 1,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  A_InstrAddress,
    output logic               C_IMRead,
    input  logic [INSTR_W-1:0] D_Instruction,
    output logic [INSTR_W-1:0] D_IR,
    output logic [ADDR_W-1:0]  D_IRPC,
    output logic               C_IRValid,
    input  logic               C_DecodeReady,
    input  logic               C_Redirect,
    input  logic [ADDR_W-1:0]  A_RedirectPC
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0]     pc;
    logic [IM_LATENCY-1:0] stage_valid;
    logic [ADDR_W-1:0]     stage_pc [IM_LATENCY];
    logic [CNT_W-1:0]      occupancy;
    logic                  head_valid;
    logic                  pop;
    logic                  push;
    logic                  issue;
    entry_t                push_entry;
    entry_t                head;
    int                    inflight;

    assign pop        = head_valid && C_DecodeReady;
    // A return that coincides with a redirect belongs to the abandoned path.
    assign push       = stage_valid[IM_LATENCY-1] && !C_Redirect;
    assign push_entry = '{pc: stage_pc[IM_LATENCY-1], instr: D_Instruction};

    // NOTE: combinational outputs get a default first so no path leaves them unassigned (no latch).
    always_comb begin
        inflight = 0;
        for (int i = 0; i < IM_LATENCY; i++) begin
            inflight += int'(stage_valid[i]);
        end
    end

    // Every in-flight read already owns a buffer slot, so the FIFO can never overflow.
    assign issue = !rst && !C_Redirect
                   && ((int'(occupancy) - int'(pop) + inflight) < FIFO_DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            stage_valid <= '0;
        end else if (C_Redirect) begin
            pc          <= A_RedirectPC;
            stage_valid <= '0;
        end else begin
            if (issue) begin
                pc <= pc + ADDR_W'(1);
            end
            stage_valid[0] <= issue;
            for (int i = 1; i < IM_LATENCY; i++) begin
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    // Addresses travel alongside the valid bits; only the valid bits need clearing.
    always_ff @(posedge clk) begin
        stage_pc[0] <= pc;
        for (int i = 1; i < IM_LATENCY; i++) begin
            stage_pc[i] <= stage_pc[i-1];
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (C_Redirect),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .occupancy  (occupancy)
    );

    assign A_InstrAddress = pc;
    assign C_IMRead       = issue;
    assign D_IR           = head.instr;
    assign D_IRPC         = head.pc;
    assign C_IRValid      = head_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: a latency-1 / depth-2 unit under stream, backpressure, reset, redirect and wrap,
// alongside a latency-3 / depth-4 unit running a continuous stream.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst;

    logic [15:0] addr_a, instr_a, ir_a, irpc_a, rpc_a;
    logic        imread_a, valid_a, ready_a, redirect_a;

    logic [15:0] addr_b, instr_b, ir_b, irpc_b;
    logic        imread_b, valid_b;

    logic [15:0] mem_a;
    logic [15:0] pipe_b [3];

    logic [15:0] wrap_seq [6] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};

    int passed = 0;
    int failed = 0;
    int total  = 0;

    instruction_fetch_unit u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .A_InstrAddress (addr_a),
        .C_IMRead       (imread_a),
        .D_Instruction  (instr_a),
        .D_IR           (ir_a),
        .D_IRPC         (irpc_a),
        .C_IRValid      (valid_a),
        .C_DecodeReady  (ready_a),
        .C_Redirect     (redirect_a),
        .A_RedirectPC   (rpc_a)
    );

    instruction_fetch_unit #(
        .IM_LATENCY (3),
        .FIFO_DEPTH (4)
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .A_InstrAddress (addr_b),
        .C_IMRead       (imread_b),
        .D_Instruction  (instr_b),
        .D_IR           (ir_b),
        .D_IRPC         (irpc_b),
        .C_IRValid      (valid_b),
        .C_DecodeReady  (1'b1),
        .C_Redirect     (1'b0),
        .A_RedirectPC   (16'h0000)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h1111;
            16'h0001: return 16'h2222;
            16'h0002: return 16'h3333;
            16'h0003: return 16'h4444;
            default:  return {4'hC, a[11:0]};
        endcase
    endfunction

    // Instruction memories: data for an issue appears IM_LATENCY cycles later; idle cycles return junk.
    always @(posedge clk) begin
        mem_a <= imread_a ? mem_val(addr_a) : 16'hDEAD;
    end
    assign instr_a = mem_a;

    always @(posedge clk) begin
        pipe_b[0] <= imread_b ? mem_val(addr_b) : 16'hDEAD;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign instr_b = pipe_b[2];

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, apply this cycle's inputs, let them settle.
    task automatic start_cycle(input logic r, input logic red, input logic rdy, input logic [15:0] rpc);
        @(posedge clk);
        #1;
        rst        = r;
        redirect_a = red;
        ready_a    = rdy;
        rpc_a      = rpc;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        redirect_a = 1'b0;
        ready_a    = 1'b1;
        rpc_a      = 16'h0000;

        // Reset state, observed while rst is still high.
        start_cycle(1'b1, 1'b0, 1'b1, 16'h0000);
        check1 ("reset_imread_a", imread_a, 1'b0);
        check16("reset_addr_a",   addr_a,   16'h0000);
        check1 ("reset_valid_a",  valid_a,  1'b0);
        check16("reset_ir_a",     ir_a,     16'h0000);
        check16("reset_irpc_a",   irpc_a,   16'h0000);
        check1 ("reset_imread_b", imread_b, 1'b0);
        check1 ("reset_valid_b",  valid_b,  1'b0);

        // Basic stream on both units.
        for (int c = 0; c < 8; c++) begin
            start_cycle(1'b0, 1'b0, 1'b1, 16'h0000);
            check1 ("stream_imread_a", imread_a, 1'b1);
            check16("stream_addr_a",   addr_a,   16'(c));
            if (c >= 2) begin
                check1 ("stream_valid_a", valid_a, 1'b1);
                check16("stream_ir_a",    ir_a,    mem_val(16'(c - 2)));
                check16("stream_irpc_a",  irpc_a,  16'(c - 2));
            end else begin
                check1 ("stream_idle_a",  valid_a, 1'b0);
            end
            check1 ("stream_imread_b", imread_b, 1'b1);
            check16("stream_addr_b",   addr_b,   16'(c));
            if (c >= 4) begin
                check1 ("stream_valid_b", valid_b, 1'b1);
                check16("stream_ir_b",    ir_b,    mem_val(16'(c - 4)));
                check16("stream_irpc_b",  irpc_b,  16'(c - 4));
            end else begin
                check1 ("stream_idle_b",  valid_b, 1'b0);
            end
        end

        // Mid-operation reset with reads in flight; decode stalls from the first cycle after it.
        start_cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        check1("rst_cycle_imread_a", imread_a, 1'b0);
        check1("rst_cycle_imread_b", imread_b, 1'b0);

        for (int r = 0; r < 14; r++) begin
            start_cycle(1'b0, 1'b0, (r >= 10), 16'h0000);
            if (r == 0) begin
                check1 ("post_rst_valid_a", valid_a,  1'b0);
                check16("post_rst_ir_a",    ir_a,     16'h0000);
                check16("post_rst_irpc_a",  irpc_a,   16'h0000);
                check16("post_rst_addr_a",  addr_a,   16'h0000);
                check1 ("post_rst_imread_a", imread_a, 1'b1);
                check1 ("post_rst_valid_b", valid_b,  1'b0);
                check16("post_rst_ir_b",    ir_b,     16'h0000);
                check16("post_rst_irpc_b",  irpc_b,   16'h0000);
                check16("post_rst_addr_b",  addr_b,   16'h0000);
            end else if (r == 1) begin
                check1 ("bp_valid_a",  valid_a,  1'b0);
                check16("bp_addr_a",   addr_a,   16'h0001);
                check1 ("bp_imread_a", imread_a, 1'b1);
            end else if (r < 10) begin
                check1 ("bp_hold_valid_a",  valid_a,  1'b1);
                check16("bp_hold_ir_a",     ir_a,     16'h1111);
                check16("bp_hold_irpc_a",   irpc_a,   16'h0000);
                check1 ("bp_hold_imread_a", imread_a, 1'b0);
                check16("bp_hold_addr_a",   addr_a,   16'h0002);
            end else begin
                check1 ("bp_drain_valid_a",  valid_a,  1'b1);
                check16("bp_drain_ir_a",     ir_a,     mem_val(16'(r - 10)));
                check16("bp_drain_irpc_a",   irpc_a,   16'(r - 10));
                check1 ("bp_drain_imread_a", imread_a, 1'b1);
                check16("bp_drain_addr_a",   addr_a,   16'(r - 8));
            end
            if (r >= 1 && r < 4) begin
                check1("lat3_idle_b", valid_b, 1'b0);
            end else if (r >= 4 && r < 8) begin
                check1 ("lat3_valid_b", valid_b, 1'b1);
                check16("lat3_irpc_b",  irpc_b,  16'(r - 4));
                check16("lat3_ir_b",    ir_b,    mem_val(16'(r - 4)));
            end
        end

        // Redirect with one entry buffered and one read in flight, concurrent with a pop.
        start_cycle(1'b0, 1'b1, 1'b1, 16'h0040);
        check1 ("redir_imread_a", imread_a, 1'b0);
        check16("redir_addr_a",   addr_a,   16'h0006);
        check1 ("redir_head_a",   valid_a,  1'b1);
        check16("redir_irpc_a",   irpc_a,   16'h0004);

        for (int k = 0; k < 4; k++) begin
            start_cycle(1'b0, 1'b0, 1'b1, 16'h0000);
            check1 ("redir_post_imread_a", imread_a, 1'b1);
            check16("redir_post_addr_a",   addr_a,   16'h0040 + 16'(k));
            if (k >= 2) begin
                check1 ("redir_post_valid_a", valid_a, 1'b1);
                check16("redir_post_irpc_a",  irpc_a,  16'h0040 + 16'(k - 2));
                check16("redir_post_ir_a",    ir_a,    mem_val(16'h0040 + 16'(k - 2)));
            end else begin
                check1 ("redir_flushed_a",    valid_a, 1'b0);
            end
        end

        // Back-to-back redirects (the second wins) into an address range that wraps.
        start_cycle(1'b0, 1'b1, 1'b1, 16'h1234);
        check1("b2b_first_imread_a", imread_a, 1'b0);
        start_cycle(1'b0, 1'b1, 1'b1, 16'hFFFE);
        check1 ("b2b_second_imread_a", imread_a, 1'b0);
        check16("b2b_second_addr_a",   addr_a,   16'h1234);
        check1 ("b2b_second_valid_a",  valid_a,  1'b0);

        for (int k = 0; k < 6; k++) begin
            start_cycle(1'b0, 1'b0, 1'b1, 16'h0000);
            check1 ("wrap_imread_a", imread_a, 1'b1);
            check16("wrap_addr_a",   addr_a,   wrap_seq[k]);
            if (k >= 2) begin
                check1 ("wrap_valid_a", valid_a, 1'b1);
                check16("wrap_irpc_a",  irpc_a,  wrap_seq[k - 2]);
                check16("wrap_ir_a",    ir_a,    mem_val(wrap_seq[k - 2]));
            end else begin
                check1 ("wrap_idle_a",  valid_a, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
